// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - ARM conditional-execution unit: NZCV flags, gated commit strobes, retire counters
module cond_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             Stall,
   input  logic             ClrCnt,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] ExecCount,
   output logic [CNT_W-1:0] SkipCount
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_ok;
   logic commit;

   assign flag_n = Flags[3];
   assign flag_z = Flags[2];
   assign flag_c = Flags[1];
   assign flag_v = Flags[0];

   // Condition is always judged against the registered flags, never this cycle's ALU result.
   always_comb begin
      cond_ok = 1'b0;
      case (Cond)
         4'b0000: cond_ok = flag_z;
         4'b0001: cond_ok = ~flag_z;
         4'b0010: cond_ok = flag_c;
         4'b0011: cond_ok = ~flag_c;
         4'b0100: cond_ok = flag_n;
         4'b0101: cond_ok = ~flag_n;
         4'b0110: cond_ok = flag_v;
         4'b0111: cond_ok = ~flag_v;
         4'b1000: cond_ok = flag_c & ~flag_z;
         4'b1001: cond_ok = ~flag_c | flag_z;
         4'b1010: cond_ok = (flag_n == flag_v);
         4'b1011: cond_ok = (flag_n != flag_v);
         4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ok = flag_z | (flag_n != flag_v);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   assign CondEx   = cond_ok;
   assign commit   = cond_ok & ~Stall & ~reset;
   assign PCSrc    = PCS  & commit;
   assign RegWrite = RegW & commit;
   assign MemWrite = MemW & commit;

   // N,Z and C,V are separate write groups so logical ops can leave C,V intact.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Flags <= 4'b0000;
      end else begin
         if (FlagW[1] & commit) Flags[3:2] <= ALUFlags[3:2];
         if (FlagW[0] & commit) Flags[1:0] <= ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ExecCount <= '0;
         SkipCount <= '0;
      end else if (ClrCnt) begin
         ExecCount <= '0;
         SkipCount <= '0;
      end else if (!Stall) begin
         if (cond_ok) begin
            if (ExecCount != CNT_MAX) ExecCount <= ExecCount + CNT_ONE;
         end else begin
            if (SkipCount != CNT_MAX) SkipCount <= SkipCount + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - randomized and directed self-checking bench for cond_unit
module tb_cond_unit;

   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    Cond = 4'b0;
   logic [3:0]    ALUFlags = 4'b0;
   logic [1:0]    FlagW = 2'b0;
   logic          PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, Stall = 1'b0, ClrCnt = 1'b0;
   logic          PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0]    Flags;
   logic [CW-1:0] ExecCount, SkipCount;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] m_flags = 4'b0;
   int         m_exec  = 0;
   int         m_skip  = 0;

   cond_unit #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .Stall(Stall), .ClrCnt(ClrCnt),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .Flags(Flags), .ExecCount(ExecCount), .SkipCount(SkipCount)
   );

   always #5 clk = ~clk;

   // Odd encodings are the negation of the even one below them; 1111 negates AL.
   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      logic ce;
      if (reset) begin
         m_flags = 4'b0;
         m_exec  = 0;
         m_skip  = 0;
      end else begin
         ce = cond_pass(Cond, m_flags);
         if (ce && !Stall && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
         if (ce && !Stall && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
         if (ClrCnt) begin
            m_exec = 0;
            m_skip = 0;
         end else if (!Stall) begin
            if (ce) m_exec = (m_exec < MAXC) ? m_exec + 1 : MAXC;
            else    m_skip = (m_skip < MAXC) ? m_skip + 1 : MAXC;
         end
      end
   end

   always @(negedge clk) begin
      logic ce, cm;
      ce = cond_pass(Cond, m_flags);
      cm = ce && !Stall && !reset;
      check("cmp_condex",   32'(CondEx),    32'(ce));
      check("cmp_pcsrc",    32'(PCSrc),     32'(PCS && cm));
      check("cmp_regwrite", 32'(RegWrite),  32'(RegW && cm));
      check("cmp_memwrite", 32'(MemWrite),  32'(MemW && cm));
      check("cmp_flags",    32'(Flags),     32'(m_flags));
      check("cmp_exec",     32'(ExecCount), 32'(m_exec));
      check("cmp_skip",     32'(SkipCount), 32'(m_skip));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                        input logic pcs, input logic rw, input logic mw,
                        input logic st, input logic clr);
      Cond = c; FlagW = fw; ALUFlags = alu;
      PCS = pcs; RegW = rw; MemW = mw; Stall = st; ClrCnt = clr;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] sc [4];
      logic       se [4];

      // Reset state
      drive(4'b1110, 2'b11, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("rst_flags", 32'(Flags), 32'h0);
      check("rst_exec", 32'(ExecCount), 32'h0);
      check("rst_regwrite", 32'(RegWrite), 32'h0);
      check("rst_al", 32'(CondEx), 32'h1);
      Cond = 4'b0000; #1;
      check("rst_eq", 32'(CondEx), 32'h0);
      Cond = 4'b0001; #1;
      check("rst_ne", 32'(CondEx), 32'h1);
      tick();
      reset = 1'b0;
      drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // AL commit
      drive(4'b1110, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      check("al_regwrite", 32'(RegWrite), 32'h1);
      tick();
      check("al_flags", 32'(Flags), 32'h4);
      check("al_exec", 32'(ExecCount), 32'h1);

      // EQ / NE after Z set
      drive(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
      check("eq_memwrite", 32'(MemWrite), 32'h1);
      tick();
      drive(4'b0001, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      check("ne_pcsrc", 32'(PCSrc), 32'h0);
      tick();
      check("ne_skip", 32'(SkipCount), 32'h1);

      // Split flag groups
      drive(4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("split_zero", 32'(Flags), 32'h0);
      drive(4'b1110, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("split_nz", 32'(Flags), 32'hC);
      drive(4'b1110, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("split_cv", 32'(Flags), 32'hF);

      // Signed conditions, N=1 V=0
      drive(4'b1110, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      sc = '{4'b1010, 4'b1011, 4'b1100, 4'b1101};
      se = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive(sc[i], 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
         check($sformatf("signed_n_%b", sc[i]), 32'(CondEx), 32'(se[i]));
         tick();
      end
      // N=1 V=1
      drive(4'b1110, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      sc = '{4'b1010, 4'b1100, 4'b1101, 4'b1011};
      se = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive(sc[i], 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
         check($sformatf("signed_nv_%b", sc[i]), 32'(CondEx), 32'(se[i]));
         tick();
      end
      drive(4'b1111, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); #1;
      check("nv_condex", 32'(CondEx), 32'h0);
      check("nv_strobes", 32'({PCSrc, RegWrite, MemWrite}), 32'h0);
      tick();
      check("nv_flags", 32'(Flags), 32'h9);

      // Clear under stall, then stall hold and release
      drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
      check("clr_stall_exec", 32'(ExecCount), 32'h0);
      check("clr_stall_skip", 32'(SkipCount), 32'h0);
      drive(4'b1110, 2'b11, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); #1;
      check("stall_regwrite", 32'(RegWrite), 32'h0);
      check("stall_condex", 32'(CondEx), 32'h1);
      tick();
      check("stall_flags", 32'(Flags), 32'h9);
      check("stall_exec", 32'(ExecCount), 32'h0);
      Stall = 1'b0; #1;
      check("release_regwrite", 32'(RegWrite), 32'h1);
      tick();
      check("release_flags", 32'(Flags), 32'h2);
      check("release_exec", 32'(ExecCount), 32'h1);

      // Saturation and clear
      drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) tick();
      check("sat_exec", 32'(ExecCount), 32'hF);
      ClrCnt = 1'b1; tick();
      check("clr_exec", 32'(ExecCount), 32'h0);
      ClrCnt = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      Cond = 4'b0000; tick();
      check("pre_rst_exec", 32'(ExecCount), 32'h3);
      check("pre_rst_skip", 32'(SkipCount), 32'h1);
      drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b1; #1;
      check("async_flags", 32'(Flags), 32'h0);
      check("async_exec", 32'(ExecCount), 32'h0);
      check("async_skip", 32'(SkipCount), 32'h0);
      check("async_regwrite", 32'(RegWrite), 32'h0);
      tick();
      reset = 1'b0;
      Stall = 1'b1;
      tick();

      // Randomized phase
      for (int i = 0; i < 800; i++) begin
         drive(4'($urandom), 2'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 24) == 0));
         if ($urandom_range(0, 3) == 0) Cond = 4'b1110;
         reset = ($urandom_range(0, 99) < 2);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit for the single-cycle ARM core. It sits between the instruction decoder and the datapath/memory. It consumes the decoder's raw control strobes (PCS, RegW, MemW, FlagW) plus the instruction condition field. It holds the architectural NZCV flag register and emits the gated write/branch strobes that actually commit state. Two saturating retire counters are included for executed and squashed instructions.

## Interface
- CNT_W, 16, width of each retire counter

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- Cond  in  4  instruction bits [31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  in  2  decoder flag-write request: [1] = N,Z group, [0] = C,V group
- PCS  in  1  decoder PC-write request
- RegW  in  1  decoder register-write request
- MemW  in  1  decoder memory-write request
- Stall  in  1  hold: no state commits this cycle
- ClrCnt  in  1  synchronous clear of both counters
- PCSrc  out  1  gated PC write
- RegWrite  out  1  gated register write
- MemWrite  out  1  gated memory write
- CondEx  out  1  condition passed for current instruction
- Flags  out  4  registered {N,Z,C,V}
- ExecCount  out  CNT_W  executed-instruction count
- SkipCount  out  CNT_W  squashed-instruction count

## Operation
- The condition is evaluated combinationally against the registered Flags (N=Flags[3], Z=[2], C=[1], V=[0]):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111 is unimplemented and yields CondEx=0, so the instruction is squashed.
- Commit = CondEx & !Stall & !reset.
- Strobe gating: PCSrc = PCS & Commit, RegWrite = RegW & Commit, MemWrite = MemW & Commit.
- Flag update on the clock edge:
  - Flags[3:2] <= ALUFlags[3:2] when FlagW[1] & Commit.
  - Flags[1:0] <= ALUFlags[1:0] when FlagW[0] & Commit.
  - The two groups are independent; otherwise Flags hold.
- Counters, on each edge with Stall=0:
  - CondEx=1 increments ExecCount; CondEx=0 increments SkipCount.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- ClrCnt=1 zeroes both counters on the edge and takes priority over increment, regardless of Stall.
- Stall=1 holds Flags and both counters, and forces PCSrc/RegWrite/MemWrite to 0. CondEx is still reported.

## Timing
- Reset (asynchronous, immediate):
  - Flags=0000, ExecCount=0, SkipCount=0.
  - PCSrc/RegWrite/MemWrite=0 while reset is high.
  - CondEx reflects Flags=0000 (EQ→0, NE→1, AL→1).
- PCSrc, RegWrite, MemWrite and CondEx are combinational, with zero-cycle latency from Cond/strobes/Stall.
- Flags and counters have one-cycle latency. A flag write in cycle n is visible to Cond evaluation in cycle n+1. An instruction never sees its own flag result.
- Simultaneous flag write and condition read in the same cycle: the condition uses pre-update flags.
- Reset asserted mid-cycle clears state at once. Deassertion takes effect at the next rising edge: the first commit is possible in the first full cycle after release.
- A counter at saturation with further increments holds its value; ClrCnt in that cycle yields 0.

## Test plan
- Reset then AL: Cond=1110, RegW=1, FlagW=11, ALUFlags=0100 → RegWrite=1 same cycle; Flags=0100 next cycle; ExecCount=1.
- EQ/NE after Z set: Flags=0100, Cond=0000 MemW=1 → MemWrite=1; Cond=0001 PCS=1 → PCSrc=0, SkipCount increments.
- Split flag groups: Flags=0000, FlagW=10, ALUFlags=1111 → Flags=1100. Then FlagW=01, ALUFlags=0011 → Flags=1111.
- Signed conditions: Flags=1000 (N=1, V=0) → GE=0, LT=1, GT=0, LE=1. Flags=1001 → GE=1, GT=1, LE=0. Cond=1111 → CondEx=0 and no strobes.
- Stall: AL with RegW=1, FlagW=11, Stall=1 → RegWrite=0, Flags and counters unchanged. Release → commit and ExecCount+1.
- Saturation/clear: CNT_W=4, 20 executed cycles → ExecCount=15. ClrCnt with a simultaneous executed instruction → ExecCount=0. Async reset mid-run → all counters and Flags 0 immediately.
